ifetch_responder: RTL and testbench

- Memory-side responder for the instruction fetch unit's request interface (rw_flag/PC/next_PC/len in; read_data/mem_busy/mem_done/cache_hit1/cache_hit2 out).
- Holds a direct-mapped instruction cache and looks up both PC and next_PC every cycle.
- On a PC miss, reads the word byte-serially from the 8-bit RAM port, returns it with a one-cycle mem_done pulse, and fills the cache.
- Sits between the fetch unit and the RAM arbiter.

---
 rtl/ifetch_responder.sv | 145 ++++++++++++++
 tb/tb_ifetch_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// Memory-side responder for the instruction fetch unit: a direct-mapped one-word-line
// instruction cache with dual lookup, backed by a byte-serial refill from an 8-bit RAM port.
module ifetch_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INST_W     = 32,
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [1:0]        rw_flag,
    input  logic [ADDR_W-1:0] PC,
    input  logic [1:0]        len,
    input  logic [ADDR_W-1:0] next_PC,
    output logic [INST_W-1:0] read_data,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              cache_hit1,
    output logic [INST_W-1:0] cache_data1,
    output logic              cache_hit2,
    output logic [INST_W-1:0] cache_data2,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [7:0]        mem_din,
    output logic              mem_wr
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;
    localparam int unsigned LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [INST_W-1:0]   read_data_q, read_data_d;
    logic                fill_en;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [INST_W-1:0]   data_q [LINES];

    logic [INDEX_BITS-1:0] idx1, idx2, fill_idx;
    logic [TAG_W-1:0]      tag1, tag2, fill_tag;

    // Word-offset bits and the write flag carry no information for this responder.
    logic unused_bits;
    assign unused_bits = ^{rw_flag[1], PC[1:0], next_PC[1:0]};

    assign idx1     = PC[INDEX_BITS+1:2];
    assign tag1     = PC[ADDR_W-1:INDEX_BITS+2];
    assign idx2     = next_PC[INDEX_BITS+1:2];
    assign tag2     = next_PC[ADDR_W-1:INDEX_BITS+2];
    assign fill_idx = base_q[INDEX_BITS+1:2];
    assign fill_tag = base_q[ADDR_W-1:INDEX_BITS+2];

    always_comb begin
        cache_hit1  = valid_q[idx1] && (tag_q[idx1] == tag1);
        cache_data1 = data_q[idx1];
        cache_hit2  = valid_q[idx2] && (tag_q[idx2] == tag2);
        cache_data2 = data_q[idx2];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        mem_a_d     = mem_a_q;
        read_data_d = read_data_q;
        fill_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rw_flag[0] && (len == 2'b11) && !cache_hit1) begin
                    base_d  = PC;
                    mem_a_d = PC;
                    cnt_d   = 3'd0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // cnt_q counts issued addresses; the byte for address k-1 is on mem_din now.
                case (cnt_q)
                    3'd1:    read_data_d[7:0]   = mem_din;
                    3'd2:    read_data_d[15:8]  = mem_din;
                    3'd3:    read_data_d[23:16] = mem_din;
                    3'd4:    read_data_d[31:24] = mem_din;
                    default: ;
                endcase
                if (cnt_q < 3'd3) begin
                    mem_a_d = mem_a_q + 1'b1;
                end
                if (cnt_q == 3'd4) begin
                    cnt_d   = 3'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                fill_en = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            base_q      <= '0;
            mem_a_q     <= '0;
            read_data_q <= '0;
            valid_q     <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            mem_a_q     <= mem_a_d;
            read_data_q <= read_data_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= read_data_q;
        end
    end

    assign read_data = read_data_q;
    assign mem_busy  = (state_q == StFetch);
    assign mem_done  = (state_q == StDone);
    assign mem_a     = mem_a_q;
    assign mem_wr    = 1'b0;

endmodule

// File: tb/tb_ifetch_responder.sv
// Bench for ifetch_responder: byte RAM model plus a slot-occupancy cache model; directed
// scenarios followed by randomized fills and lookups.
module tb_ifetch_responder;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [1:0]  rw_flag, len;
    logic [31:0] PC, next_PC;
    logic [31:0] read_data, cache_data1, cache_data2, mem_a;
    logic        mem_busy, mem_done, cache_hit1, cache_hit2, mem_wr;
    logic [7:0]  mem_din = 8'h00;

    logic [7:0]  ram [0:4095];
    int          errors = 0;
    int          checks = 0;

    // Model: which word address occupies each of the 128 slots.
    bit          m_valid [128];
    logic [31:0] m_addr  [128];
    logic [31:0] m_data  [128];

    ifetch_responder #(
        .ADDR_W(32),
        .INST_W(32),
        .INDEX_BITS(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .rw_flag(rw_flag),
        .PC(PC),
        .len(len),
        .next_PC(next_PC),
        .read_data(read_data),
        .mem_busy(mem_busy),
        .mem_done(mem_done),
        .cache_hit1(cache_hit1),
        .cache_data1(cache_data1),
        .cache_hit2(cache_hit2),
        .cache_data2(cache_data2),
        .mem_a(mem_a),
        .mem_din(mem_din),
        .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency; output holds while rdy is low.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[11:0]];
    end

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % 128);
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_addr[slot(a)] / 4 == a / 4);
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram[(a + 3) % 4096], ram[(a + 2) % 4096], ram[(a + 1) % 4096], ram[a % 4096]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_lookup(input string tag);
        #1;
        chk({tag, "_hit1"}, {31'b0, cache_hit1}, {31'b0, m_hit(PC)});
        if (m_hit(PC)) chk({tag, "_data1"}, cache_data1, m_data[slot(PC)]);
        chk({tag, "_hit2"}, {31'b0, cache_hit2}, {31'b0, m_hit(next_PC)});
        if (m_hit(next_PC)) chk({tag, "_data2"}, cache_data2, m_data[slot(next_PC)]);
    endtask

    // Called in the request cycle R. p counts enabled clock edges since R, so every
    // expected value follows from the nominal timeline shifted by any rdy drops.
    task automatic run_miss(input logic [31:0] base, input logic [31:0] nxt,
                            input int drop_start, input int drop_len);
        int          p;
        logic        prev_rdy;
        logic [31:0] w;
        p       = 0;
        w       = ram_word(base);
        PC      = base;
        next_PC = nxt;
        rw_flag = 2'b01;
        len     = 2'b11;
        rdy     = 1'b1;
        #1;
        chk("req_hit1", {31'b0, cache_hit1}, {31'b0, m_hit(base)});
        for (int c = 1; c <= 6 + drop_len; c++) begin
            prev_rdy = rdy;
            tick();
            if (prev_rdy) p++;
            rw_flag = 2'b00;
            rdy     = !(c >= drop_start && c < drop_start + drop_len);
            chk("busy", {31'b0, mem_busy}, {31'b0, (p >= 1 && p <= 5)});
            chk("done", {31'b0, mem_done}, {31'b0, (p == 6)});
            if (p >= 1 && p <= 4) chk("mem_a", mem_a, base + p - 1);
            if (p == 6) chk("read_data", read_data, w);
        end
        chk("done_progress", p, 6);
        m_valid[slot(base)] = 1'b1;
        m_addr[slot(base)]  = base;
        m_data[slot(base)]  = w;
        rdy = 1'b1;
        tick();
        chk("post_done", {31'b0, mem_done}, 32'd0);
        chk("post_busy", {31'b0, mem_busy}, 32'd0);
        chk("bypass_hit", {31'b0, cache_hit1}, 32'd1);
        chk_lookup("bypass");
    endtask

    // The fetch unit never requests while a fetch is outstanding.
    always @(negedge clk) begin
        if (!rst && (mem_busy || mem_done)) begin
            checks++;
            assert (rw_flag[0] === 1'b0)
            else begin
                errors++;
                $error("FAIL busy_request: observed %b expected 0", rw_flag[0]);
            end
        end
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;
        model_reset();
        rst = 1'b1; rdy = 1'b1; rw_flag = 2'b00; len = 2'b00; PC = '0; next_PC = '0;
        tick();
        tick();
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        chk("rst_done", {31'b0, mem_done}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk_lookup("rst");
        rst = 1'b0;

        // First fill of PC=0.
        run_miss(32'h0, 32'h4, 0, 0);
        chk("fill0_word", m_data[0], 32'h0000_0013);

        // Hitting request: no RAM traffic.
        PC = 32'h0; next_PC = 32'h4; rw_flag = 2'b01; len = 2'b11;
        #1;
        chk("hit_hit1", {31'b0, cache_hit1}, 32'd1);
        chk("hit_data1", cache_data1, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hit_busy", {31'b0, mem_busy}, 32'd0);
            chk("hit_done", {31'b0, mem_done}, 32'd0);
            chk("hit_mem_a", mem_a, 32'h3);
        end
        rw_flag = 2'b00;

        // Dual lookup.
        run_miss(32'h4, 32'h8, 0, 0);
        run_miss(32'h8, 32'hC, 0, 0);
        PC = 32'h4; next_PC = 32'h8;
        chk_lookup("dual48");
        chk("dual_hit2", {31'b0, cache_hit2}, 32'd1);
        chk("dual_data2", cache_data2, ram_word(32'h8));
        next_PC = 32'hC;
        #1;
        chk("dual_hit2_unfilled", {31'b0, cache_hit2}, 32'd0);

        // Ignored requests: write flag, short length.
        PC = 32'h40; rw_flag = 2'b10; len = 2'b11;
        tick(); tick();
        chk("ign_wr_busy", {31'b0, mem_busy}, 32'd0);
        rw_flag = 2'b01; len = 2'b01;
        tick(); tick();
        chk("ign_len_busy", {31'b0, mem_busy}, 32'd0);
        chk("ign_mem_a", mem_a, 32'hB);
        rw_flag = 2'b00;
        tick();

        // Conflict at index 0.
        run_miss(32'h200, 32'h204, 0, 0);
        PC = 32'h0; next_PC = 32'h200;
        chk_lookup("conflict");
        chk("conflict_hit1", {31'b0, cache_hit1}, 32'd0);
        chk("conflict_hit2", {31'b0, cache_hit2}, 32'd1);
        run_miss(32'h0, 32'h4, 0, 0);

        // Reset in R+3 abandons the fetch and clears the cache.
        PC = 32'h100; next_PC = 32'h104; rw_flag = 2'b01; len = 2'b11;
        tick();
        rw_flag = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rstmid_busy", {31'b0, mem_busy}, 32'd0);
        chk("rstmid_done", {31'b0, mem_done}, 32'd0);
        chk("rstmid_data", read_data, 32'd0);
        chk_lookup("rstmid");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid_no_done", {31'b0, mem_done}, 32'd0);
        end
        run_miss(32'h100, 32'h104, 0, 0);

        // rdy dropped for three cycles starting at R+2.
        run_miss(32'h300, 32'h304, 2, 3);

        // Randomized fills with random rdy drops.
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 1023)) << 2;
            if (m_hit(a)) begin
                PC = a; next_PC = a + 4;
                chk_lookup("rnd_hit");
                tick();
            end else begin
                run_miss(a, a + 4, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
            end
        end
        for (int i = 0; i < 10; i++) begin
            PC = m_addr[$urandom_range(0, 127)];
            if (PC === 'x) PC = 32'h0;
            next_PC = 32'($urandom_range(0, 1023)) << 2;
            chk_lookup("rnd_look");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
